// File: rtl/alu_datapath_seq.sv
// A/B/ALUOut datapath stage with operand muxes, single-cycle ALU and iterative shift-add multiplier.
// Latency: single-cycle ops are combinational; a multiply is busy for WIDTH cycles, then Done pulses for one cycle.
// Backpressure: Start is ignored while busy; ALUOutWrite is ignored while busy and in the Done cycle.
module alu_datapath_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] PC,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] ExType,
    input  logic [WIDTH-1:0] Shifter,
    input  logic             AWrite,
    input  logic             BWrite,
    input  logic [2:0]       ALUAinput,
    input  logic [1:0]       ALUBinput,
    input  logic [3:0]       ALUOp,
    input  logic             Start,
    input  logic             ALUOutWrite,
    output logic [WIDTH-1:0] ALUOut,
    output logic [WIDTH-1:0] ALUOutReg,
    output logic [WIDTH-1:0] ProdHi,
    output logic             Zero,
    output logic             OverFlow,
    output logic             Busy,
    output logic             Done
);
    localparam int SH = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [WIDTH-1:0]   a_reg_q, a_reg_d;
    logic [WIDTH-1:0]   b_reg_q, b_reg_d;
    logic [WIDTH-1:0]   alu_out_reg_q, alu_out_reg_d;
    logic [WIDTH-1:0]   prod_hi_q, prod_hi_d;
    logic [1:0]         state_q, state_d;
    logic [SH-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [WIDTH-1:0]   src_a, src_b;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   sum, diff;
    logic [SH-1:0]      shamt;
    logic [WIDTH-1:0]   step_add;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic               mul_go;

    // Operand registers load whenever enabled; the multiplier keeps private copies.
    always_comb begin
        a_reg_d = AWrite ? A : a_reg_q;
        b_reg_d = BWrite ? B : b_reg_q;
    end

    // Operand source selection for both ALU inputs.
    always_comb begin
        src_a = a_reg_q;
        case (ALUAinput)
            3'd0:    src_a = a_reg_q;
            3'd1:    src_a = PC;
            3'd2:    src_a = C;
            3'd3:    src_a = Shifter;
            3'd4:    src_a = ExType;
            3'd5:    src_a = '0;
            3'd6:    src_a = '1;
            default: src_a = b_reg_q;
        endcase
        src_b = b_reg_q;
        case (ALUBinput)
            2'd0:    src_b = b_reg_q;
            2'd1:    src_b = ExType;
            2'd2:    src_b = WIDTH'(1);
            default: src_b = '0;
        endcase
    end

    // Single-cycle ALU; op 11 exposes the registered multiply result.
    always_comb begin
        sum     = src_a + src_b;
        diff    = src_a - src_b;
        shamt   = src_b[SH-1:0];
        alu_res = src_a;
        alu_ovf = 1'b0;
        case (ALUOp)
            4'd0: begin
                alu_res = sum;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = diff;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'd2:    alu_res = src_a & src_b;
            4'd3:    alu_res = src_a | src_b;
            4'd4:    alu_res = src_a ^ src_b;
            4'd5:    alu_res = ~(src_a | src_b);
            4'd6:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd7:    alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            4'd8:    alu_res = src_a << shamt;
            4'd9:    alu_res = src_a >> shamt;
            4'd10:   alu_res = $unsigned($signed(src_a) >>> shamt);
            4'd11:   alu_res = alu_out_reg_q;
            default: alu_res = src_a;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    always_comb begin
        step_add  = prod_q[0] ? mcand_q : '0;
        step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, step_add};
        prod_step = {step_sum, prod_q[WIDTH-1:1]};
    end

    // Multiplier sequencing and ALUOutReg write arbitration (multiplier write wins).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mcand_d       = mcand_q;
        prod_d        = prod_q;
        alu_out_reg_d = alu_out_reg_q;
        prod_hi_d     = prod_hi_q;
        mul_go        = Start && (ALUOp == 4'd11);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ALUOutWrite && (state_q == ST_IDLE)) begin
                    alu_out_reg_d = alu_res;
                end
                if (mul_go) begin
                    mcand_d = src_a;
                    prod_d  = {{WIDTH{1'b0}}, src_b};
                    cnt_d   = SH'(WIDTH - 1);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                prod_d = prod_step;
                if (cnt_q == '0) begin
                    alu_out_reg_d = prod_step[WIDTH-1:0];
                    prod_hi_d     = prod_step[2*WIDTH-1:WIDTH];
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q - SH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any multiply in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            a_reg_q       <= '0;
            b_reg_q       <= '0;
            alu_out_reg_q <= '0;
            prod_hi_q     <= '0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mcand_q       <= '0;
            prod_q        <= '0;
        end else begin
            a_reg_q       <= a_reg_d;
            b_reg_q       <= b_reg_d;
            alu_out_reg_q <= alu_out_reg_d;
            prod_hi_q     <= prod_hi_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mcand_q       <= mcand_d;
            prod_q        <= prod_d;
        end
    end

    assign ALUOut    = alu_res;
    assign ALUOutReg = alu_out_reg_q;
    assign ProdHi    = prod_hi_q;
    assign Zero      = (alu_res == '0);
    assign OverFlow  = alu_ovf;
    assign Busy      = (state_q == ST_RUN);
    assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_datapath_seq.sv
// Directed-vector bench for alu_datapath_seq with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge.
// Every wait on Done is bounded by a cycle budget.
module tb_alu_datapath_seq;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] PC, A, B, C, ExType, Shifter;
    logic        AWrite, BWrite;
    logic [2:0]  ALUAinput;
    logic [1:0]  ALUBinput;
    logic [3:0]  ALUOp;
    logic        Start, ALUOutWrite;
    logic [15:0] ALUOut, ALUOutReg, ProdHi;
    logic        Zero, OverFlow, Busy, Done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_datapath_seq #(.WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .PC(PC), .A(A), .B(B), .C(C),
        .ExType(ExType), .Shifter(Shifter), .AWrite(AWrite), .BWrite(BWrite),
        .ALUAinput(ALUAinput), .ALUBinput(ALUBinput), .ALUOp(ALUOp),
        .Start(Start), .ALUOutWrite(ALUOutWrite), .ALUOut(ALUOut),
        .ALUOutReg(ALUOutReg), .ProdHi(ProdHi), .Zero(Zero),
        .OverFlow(OverFlow), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    task automatic load_ab(input logic [15:0] a, input logic [15:0] b);
        A = a; B = b; AWrite = 1'b1; BWrite = 1'b1;
        @(posedge Clock); #1;
        AWrite = 1'b0; BWrite = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; PC = 16'h0; A = 16'h0; B = 16'h0; C = 16'h0; ExType = 16'h0; Shifter = 16'h0;
        AWrite = 0; BWrite = 0; ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd12; Start = 0; ALUOutWrite = 0;
        #2;
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", Done); end
        n_cmp++; if (ALUOutReg !== 16'h0000) begin n_bad++; $display("FAIL reset_aluoutreg: got %h want 0000", ALUOutReg); end
        n_cmp++; if (ProdHi !== 16'h0000) begin n_bad++; $display("FAIL reset_prodhi: got %h want 0000", ProdHi); end
        n_cmp++; if (ALUOut !== 16'h0000) begin n_bad++; $display("FAIL reset_areg: got %h want 0000", ALUOut); end
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    task automatic test_add;
        load_ab(16'h7FFF, 16'h0001);
        ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd0; #1;
        n_cmp++; if (ALUOut !== 16'h8000) begin n_bad++; $display("FAIL add_res: got %h want 8000", ALUOut); end
        n_cmp++; if (OverFlow !== 1'b1) begin n_bad++; $display("FAIL add_ovf: got %b want 1", OverFlow); end
        n_cmp++; if (Zero !== 1'b0) begin n_bad++; $display("FAIL add_zero: got %b want 0", Zero); end
        ALUBinput = 2'd2; #1;
        n_cmp++; if (ALUOut !== 16'h8000) begin n_bad++; $display("FAIL add_const1_res: got %h want 8000", ALUOut); end
        n_cmp++; if (OverFlow !== 1'b1) begin n_bad++; $display("FAIL add_const1_ovf: got %b want 1", OverFlow); end
    endtask

    task automatic test_sub;
        load_ab(16'h1234, 16'h1234);
        ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd1; #1;
        n_cmp++; if (ALUOut !== 16'h0000) begin n_bad++; $display("FAIL sub_eq_res: got %h want 0000", ALUOut); end
        n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL sub_eq_zero: got %b want 1", Zero); end
        n_cmp++; if (OverFlow !== 1'b0) begin n_bad++; $display("FAIL sub_eq_ovf: got %b want 0", OverFlow); end
        load_ab(16'h8000, 16'h0001); #1;
        n_cmp++; if (ALUOut !== 16'h7FFF) begin n_bad++; $display("FAIL sub_ovf_res: got %h want 7fff", ALUOut); end
        n_cmp++; if (OverFlow !== 1'b1) begin n_bad++; $display("FAIL sub_ovf_flag: got %b want 1", OverFlow); end
    endtask

    task automatic test_shift;
        load_ab(16'h0000, 16'h0004);
        Shifter = 16'h8234; ALUAinput = 3'd3; ALUBinput = 2'd0;
        ALUOp = 4'd10; #1;
        n_cmp++; if (ALUOut !== 16'hF823) begin n_bad++; $display("FAIL sra: got %h want f823", ALUOut); end
        ALUOp = 4'd9; #1;
        n_cmp++; if (ALUOut !== 16'h0823) begin n_bad++; $display("FAIL srl: got %h want 0823", ALUOut); end
        ALUOp = 4'd8; #1;
        n_cmp++; if (ALUOut !== 16'h2340) begin n_bad++; $display("FAIL sll: got %h want 2340", ALUOut); end
    endtask

    task automatic test_compare;
        load_ab(16'h8000, 16'h0001);
        ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd6; #1;
        n_cmp++; if (ALUOut !== 16'h0001) begin n_bad++; $display("FAIL slt: got %h want 0001", ALUOut); end
        n_cmp++; if (OverFlow !== 1'b0) begin n_bad++; $display("FAIL slt_ovf: got %b want 0", OverFlow); end
        ALUOp = 4'd7; #1;
        n_cmp++; if (ALUOut !== 16'h0000) begin n_bad++; $display("FAIL sltu: got %h want 0000", ALUOut); end
        n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL sltu_zero: got %b want 1", Zero); end
    endtask

    // 1234 x 5678 with a stray Start in RUN cycle 3 (plus an A reload) and ALUOutWrite held from cycle 6.
    task automatic test_mul_handshake;
        int busy_cnt = 0;
        bit got_done = 0;
        load_ab(16'h1234, 16'h5678);
        ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd11; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int i = 1; i <= 40 && !got_done; i++) begin
            if (Busy) busy_cnt++;
            if (Done) begin
                got_done = 1;
                n_cmp++; if (busy_cnt !== 16) begin n_bad++; $display("FAIL mul_busy_cycles: got %0d want 16", busy_cnt); end
                n_cmp++; if (i !== 17) begin n_bad++; $display("FAIL mul_done_cycle: got %0d want 17", i); end
                n_cmp++; if (ALUOutReg !== 16'h0060) begin n_bad++; $display("FAIL mul_lo: got %h want 0060", ALUOutReg); end
                n_cmp++; if (ProdHi !== 16'h0626) begin n_bad++; $display("FAIL mul_hi: got %h want 0626", ProdHi); end
            end else begin
                if (i == 8) begin
                    n_cmp++; if (ALUOutReg !== 16'h0000) begin n_bad++; $display("FAIL run_write_blocked: got %h want 0000", ALUOutReg); end
                end
                if (i == 3) begin Start = 1'b1; AWrite = 1'b1; A = 16'hFFFF; end
                else begin Start = 1'b0; AWrite = 1'b0; end
                if (i == 6) begin ALUOp = 4'd0; ALUOutWrite = 1'b1; end
                @(posedge Clock); #1;
            end
        end
        if (!got_done) begin n_cmp++; n_bad++; $display("FAIL mul_timeout: got no Done want Done within 40 cycles"); end
        @(posedge Clock); #1;
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b want 0", Done); end
        n_cmp++; if (ALUOutReg !== 16'h0060) begin n_bad++; $display("FAIL done_write_blocked: got %h want 0060", ALUOutReg); end
        ALUOutWrite = 1'b0; ALUOp = 4'd11;
    endtask

    // FFFF x FFFF, then Start held in the Done cycle launches 0003 x 5678.
    task automatic test_back_to_back;
        int busy_cnt = 0;
        bit got_done = 0;
        load_ab(16'hFFFF, 16'hFFFF);
        ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd11; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int i = 1; i <= 40 && !got_done; i++) begin
            if (Busy) busy_cnt++;
            if (Done) begin
                got_done = 1;
                n_cmp++; if (busy_cnt !== 16) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 16", busy_cnt); end
                n_cmp++; if (ALUOutReg !== 16'h0001) begin n_bad++; $display("FAIL ffff_lo: got %h want 0001", ALUOutReg); end
                n_cmp++; if (ProdHi !== 16'hFFFE) begin n_bad++; $display("FAIL ffff_hi: got %h want fffe", ProdHi); end
            end else begin
                if (i == 5) begin
                    n_cmp++; if (ALUOut !== 16'h0060) begin n_bad++; $display("FAIL op11_old_value: got %h want 0060", ALUOut); end
                end
                if (i == 2) begin AWrite = 1'b1; BWrite = 1'b1; A = 16'h0003; B = 16'h5678; end
                else begin AWrite = 1'b0; BWrite = 1'b0; end
                @(posedge Clock); #1;
            end
        end
        if (!got_done) begin n_cmp++; n_bad++; $display("FAIL b2b_timeout1: got no Done want Done within 40 cycles"); end
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b want 1", Busy); end
        got_done = 0;
        for (int i = 1; i <= 40 && !got_done; i++) begin
            if (Done) begin
                got_done = 1;
                n_cmp++; if (ALUOutReg !== 16'h0368) begin n_bad++; $display("FAIL b2b_lo: got %h want 0368", ALUOutReg); end
                n_cmp++; if (ProdHi !== 16'h0001) begin n_bad++; $display("FAIL b2b_hi: got %h want 0001", ProdHi); end
            end else begin
                @(posedge Clock); #1;
            end
        end
        if (!got_done) begin n_cmp++; n_bad++; $display("FAIL b2b_timeout2: got no Done want Done within 40 cycles"); end
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_abort;
        int done_seen = 0;
        int busy_seen = 0;
        ALUAinput = 3'd0; ALUBinput = 2'd0; ALUOp = 4'd11; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (4) begin @(posedge Clock); #1; end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", Busy); end
        n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", Done); end
        n_cmp++; if (ALUOutReg !== 16'h0000) begin n_bad++; $display("FAIL abort_lo: got %h want 0000", ALUOutReg); end
        n_cmp++; if (ProdHi !== 16'h0000) begin n_bad++; $display("FAIL abort_hi: got %h want 0000", ProdHi); end
        ALUOp = 4'd12; ALUAinput = 3'd0; #1;
        n_cmp++; if (ALUOut !== 16'h0000) begin n_bad++; $display("FAIL abort_areg: got %h want 0000", ALUOut); end
        ALUAinput = 3'd7; #1;
        n_cmp++; if (ALUOut !== 16'h0000) begin n_bad++; $display("FAIL abort_breg: got %h want 0000", ALUOut); end
        @(posedge Clock); #1;
        Reset = 1'b0; ALUOp = 4'd11; ALUAinput = 3'd0;
        for (int i = 0; i < 20; i++) begin
            if (Done) done_seen++;
            if (Busy) busy_seen++;
            @(posedge Clock); #1;
        end
        n_cmp++; if (done_seen !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
        n_cmp++; if (busy_seen !== 0) begin n_bad++; $display("FAIL abort_no_busy: got %0d cycles want 0", busy_seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_compare();
        test_mul_handshake();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
